// File: rtl/bit_serial_pkg.sv
// Shared types for the bit-serial adder.
// State encoding and counter-width helper.
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serial_adder_cell.sv
// Combinational one-bit full adder.
// Instantiated once by bit_serial_adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, start/busy/done handshake.
// Define BIT_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sb, res;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             s, c;
  logic             last;
  logic             accept;

  full_adder_cell u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .c  (carry),
    .s  (s),
    .co (c)
  );

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res   <= {s, res[WIDTH-1:1]};
      carry <= c;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Visible result only moves on the last bit, so partials never leak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (state == RUN && last) begin
      sum  <= {s, res[WIDTH-1:1]};
      cout <= c;
    end
  end

`ifdef BIT_SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovf <= 1'b0;
    else if (state == RUN && last) ovf <= carry ^ c;
  end
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH 8 and 13.
// Honours BIT_SERIAL_ADDER_OVF_EN when defined.
module tb_bit_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          k;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start13 = 1'b0;
  logic [12:0] a13 = '0, b13 = '0;
  logic        cin13 = 1'b0;
  logic        busy13, done13, cout13;
  logic [12:0] sum13;

`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic ovf8, ovf13;
`endif

  exp_t q8[$];
  exp_t q13[$];
  logic pdone8 = 1'b0, pdone13 = 1'b0;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  bit_serial_adder #(.WIDTH(13)) dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start13),
    .a     (a13),
    .b     (b13),
    .cin   (cin13),
    .busy  (busy13),
    .done  (done13),
    .sum   (sum13),
    .cout  (cout13)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf13)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      chk("done8_one_cycle", longint'(pdone8), 0);
      chk("busy8_in_fin", longint'(busy8), 0);
      if (q8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("sum8", longint'(sum8), longint'(e.sum[7:0]));
        chk("cout8", longint'(cout8), longint'(e.cout));
        chk("latency8", longint'(cyc), longint'(e.k + 8));
`ifdef BIT_SERIAL_ADDER_OVF_EN
        chk("ovf8", longint'(ovf8), longint'(e.ovf));
`endif
      end
    end
    pdone8 <= done8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done13) begin
      chk("done13_one_cycle", longint'(pdone13), 0);
      if (q13.size() == 0) begin
        chk("unexpected_done13", 1, 0);
      end else begin
        e = q13.pop_front();
        chk("sum13", longint'(sum13), longint'(e.sum[12:0]));
        chk("cout13", longint'(cout13), longint'(e.cout));
        chk("latency13", longint'(cyc), longint'(e.k + 13));
`ifdef BIT_SERIAL_ADDER_OVF_EN
        chk("ovf13", longint'(ovf13), longint'(e.ovf));
`endif
      end
    end
    pdone13 <= done13;
  end

  // Called at a negedge; returns at the negedge showing done.
  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      input logic ci, input logic [7:0] es,
                      input logic ec, input logic eo, input bit cb);
    int nb;
    bit seen;
    a8 = x; b8 = y; cin8 = ci; start8 = 1'b1;
    q8.push_back('{sum: 32'(es), cout: ec, ovf: eo, k: cyc + 1});
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (done8) seen = 1'b1;
      else begin
        if (busy8) nb++;
        @(negedge clk);
      end
    end
    if (!seen) chk("timeout8", 0, 1);
    if (cb) chk("busy8_cycles", longint'(nb), 8);
  endtask

  task automatic run13(input logic [12:0] x, input logic [12:0] y,
                       input logic ci);
    logic [13:0] t;
    logic        eo;
    bit          seen;
    t  = {1'b0, x} + {1'b0, y} + 14'(ci);
    eo = (x[12] == y[12]) && (t[12] != x[12]);
    a13 = x; b13 = y; cin13 = ci; start13 = 1'b1;
    q13.push_back('{sum: 32'(t[12:0]), cout: t[13], ovf: eo, k: cyc + 1});
    @(posedge clk);
    @(negedge clk);
    start13 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done13) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("timeout13", 0, 1);
  endtask

  initial begin
    logic [7:0]  x, y;
    logic [8:0]  t;
    logic        ci;
    #1;
    chk("rst_busy", longint'(busy8), 0);
    chk("rst_done", longint'(done8), 0);
    chk("rst_sum", longint'(sum8), 0);
    chk("rst_cout", longint'(cout8), 0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    chk("rst_ovf", longint'(ovf8), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    @(negedge clk);

    // start held through RUN with operands disturbed, then held into FIN
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{sum: 32'h30, cout: 1'b0, ovf: 1'b0, k: cyc + 1});
    @(posedge clk);
    repeat (3) @(negedge clk);
    a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b1;
    for (int i = 0; i < 16 && !done8; i++) @(negedge clk);
    chk("held_start_done", longint'(done8), 1);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    q8.push_back('{sum: 32'h03, cout: 1'b0, ovf: 1'b0, k: cyc + 1});
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    chk("fin_restart_busy", longint'(busy8), 1);
    chk("fin_restart_done", longint'(done8), 0);
    for (int i = 0; i < 16 && !done8; i++) @(negedge clk);
    chk("fin_restart_result", longint'(done8), 1);
    @(negedge clk);

    // abort mid-run with reset
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", longint'(busy8), 0);
    chk("abort_done", longint'(done8), 0);
    chk("abort_sum", longint'(sum8), 0);
    chk("abort_cout", longint'(cout8), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", longint'(q8.size()), 0);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);

    // back-to-back random runs: each starts in the FIN cycle of the last
    for (int i = 0; i < 500; i++) begin
      x  = 8'($urandom);
      y  = 8'($urandom);
      ci = 1'($urandom);
      t  = {1'b0, x} + {1'b0, y} + 9'(ci);
      run8(x, y, ci, t[7:0], t[8],
           (x[7] == y[7]) && (t[7] != x[7]), 1'b0);
    end
    @(negedge clk);
    for (int i = 0; i < 500; i++)
      run13(13'($urandom), 13'($urandom), 1'($urandom));
    repeat (3) @(negedge clk);
    chk("q8_drained", longint'(q8.size()), 0);
    chk("q13_drained", longint'(q13.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
